add_nibble_serial: RTL

//   Multi-cycle W-bit adder that reuses one 4-bit full-adder slice (fa4_mbit)

---
 rtl/add_nibble_serial_pkg.sv | 19 +
 rtl/add_nibble_serial_fa4_mbit.sv | 17 +
 rtl/add_nibble_serial.sv | 123 ++++++++++++
 3 files changed

// File: rtl/add_nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
package add_nibble_serial_pkg;

  // Width of the reused adder slice.
  localparam int NIBBLE = 4;

  // Controller states; the spare encoding 2'd3 is steered back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index width for n passes, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_nibble_serial_fa4_mbit.sv
// 4-bit full-adder slice reused once per nibble by the serial adder.
module fa4_mbit
  import add_nibble_serial_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
  output logic              co
);

  // Plain ripple add of one nibble plus carry-in.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, ci};
  end

endmodule

// File: rtl/add_nibble_serial.sv
// Multi-cycle W-bit adder: one 4-bit slice, one nibble per cycle, LSB first,
// carry rippled through a register between passes.
module add_nibble_serial
  import add_nibble_serial_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         co,
  output logic         busy
);

  localparam int NIB   = W / NIBBLE;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     s_q, s_d;
  logic             co_q, co_d;

  logic [NIBBLE-1:0] a_nib [NIB];
  logic [NIBBLE-1:0] b_nib [NIB];
  logic [NIBBLE-1:0] slice_a, slice_b, slice_s;
  logic              slice_co;

  // Split the latched operands into nibbles so the slice input is a simple mux.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign a_nib[gi] = a_q[gi*NIBBLE +: NIBBLE];
    assign b_nib[gi] = b_q[gi*NIBBLE +: NIBBLE];
  end

  assign slice_a = a_nib[idx_q];
  assign slice_b = b_nib[idx_q];

  fa4_mbit u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign s         = s_q;
  assign co        = co_q;

  // Next-state and datapath update for accept / per-nibble add / drain.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          s_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d[NIBBLE*idx_q +: NIBBLE] = slice_s;
        carry_d = slice_co;
        if (idx_q == IDX_LAST) begin
          co_d    = slice_co;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

endmodule
